// File: rtl/tst_seq_ctrl_pkg.sv
// Shared definitions for the test-signal sweep controller: widths, FSM encoding
// and small helpers used by the controller and its edge counters.
package tst_seq_ctrl_pkg;

  localparam int NUM_MODES_DEF = 12;
  localparam int CNT_W         = 16;
  localparam int DWELL_W       = 24;
  localparam int UPR_W         = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_MEASURE = 3'd2;
  localparam logic [2:0] ST_EVAL    = 3'd3;
  localparam logic [2:0] ST_FINISH  = 3'd4;

  // A zero-length window would never terminate, so it is stretched to one clock.
  function automatic logic [DWELL_W-1:0] eff_dwell(input logic [DWELL_W-1:0] d);
    return (d == {DWELL_W{1'b0}}) ? {{(DWELL_W-1){1'b0}}, 1'b1} : d;
  endfunction

endpackage

// File: rtl/tst_seq_ctrl_edge_cnt.sv
// Edge counter for one returned test signal: synchronizer, rising-edge detect
// and a saturating counter with synchronous clear and count enable.
module tst_edge_cnt
  import tst_seq_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sig_in,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [1:0]   sync_r;
  logic         prev_r;
  logic         rise_s;
  logic [W-1:0] cnt_r;

  assign rise_s = sync_r[1] & ~prev_r;
  assign cnt    = cnt_r;

  // two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b00;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], sig_in};
      prev_r <= sync_r[1];
    end
  end

  // saturating rising-edge counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (en && rise_s && (cnt_r != {W{1'b1}})) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/tst_seq_ctrl.sv
// Sweep controller: steps the test-signal mux selector through every mode,
// measures edge activity on both returned signals and records a pass bitmap.
module tst_seq_ctrl
  import tst_seq_ctrl_pkg::*;
#(
  parameter int NUM_MODES = NUM_MODES_DEF,
  parameter int SETTLE    = 4,
  parameter int MIN_EDGES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 manual_en,
  input  logic [UPR_W-1:0]     manual_upr,
  input  logic [DWELL_W-1:0]   dwell,
  input  logic                 sig1_in,
  input  logic                 sig2_in,
  output logic [UPR_W-1:0]     upr,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [NUM_MODES-1:0] mode_ok,
  output logic [CNT_W-1:0]     cnt1,
  output logic [CNT_W-1:0]     cnt2
);

  localparam logic [DWELL_W-1:0] SETTLE_LAST = DWELL_W'(SETTLE - 1);
  localparam logic [DWELL_W-1:0] TMR_ONE     = DWELL_W'(1);
  localparam logic [UPR_W-1:0]   MODE_LAST   = UPR_W'(NUM_MODES - 1);
  localparam logic [UPR_W-1:0]   MODE_ONE    = UPR_W'(1);
  localparam logic [CNT_W-1:0]   MIN_CNT     = CNT_W'(MIN_EDGES);

  logic [2:0]           state_r, state_nxt_s;
  logic [UPR_W-1:0]     mode_r, mode_inc_s, upr_r;
  logic [DWELL_W-1:0]   dwell_r, timer_r, dwell_last_s;
  logic                 busy_r, done_r, aborted_r;
  logic [NUM_MODES-1:0] mode_ok_r, mode_bit_s;
  logic [CNT_W-1:0]     cnt1_r, cnt2_r, cnt1_s, cnt2_s;
  logic                 start_acc_s, abort_s, last_mode_s, pass_s, clr_s, en_s;

  assign dwell_last_s = dwell_r - TMR_ONE;
  assign mode_inc_s   = mode_r + MODE_ONE;
  assign mode_bit_s   = {{(NUM_MODES-1){1'b0}}, 1'b1} << mode_r;
  assign last_mode_s  = (mode_r == MODE_LAST);
  assign pass_s       = (cnt1_s >= MIN_CNT) && (cnt2_s >= MIN_CNT);
  assign abort_s      = abort && (state_r != ST_IDLE);
  assign clr_s        = (state_r == ST_SETTLE) || start_acc_s;
  assign en_s         = (state_r == ST_MEASURE);

  assign upr     = upr_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign aborted = aborted_r;
  assign mode_ok = mode_ok_r;
  assign cnt1    = cnt1_r;
  assign cnt2    = cnt2_r;

  tst_edge_cnt #(.W(CNT_W)) u_cnt1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig1_in),
    .clr    (clr_s),
    .en     (en_s),
    .cnt    (cnt1_s)
  );

  tst_edge_cnt #(.W(CNT_W)) u_cnt2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig2_in),
    .clr    (clr_s),
    .en     (en_s),
    .cnt    (cnt2_s)
  );

  // next-state logic; abort outranks every other transition outside IDLE
  always_comb begin
    state_nxt_s = state_r;
    start_acc_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_SETTLE;
          start_acc_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (abort)                         state_nxt_s = ST_IDLE;
        else if (timer_r == SETTLE_LAST)   state_nxt_s = ST_MEASURE;
        else                               state_nxt_s = ST_SETTLE;
      end
      ST_MEASURE: begin
        if (abort)                         state_nxt_s = ST_IDLE;
        else if (timer_r == dwell_last_s)  state_nxt_s = ST_EVAL;
        else                               state_nxt_s = ST_MEASURE;
      end
      ST_EVAL: begin
        if (abort)                         state_nxt_s = ST_IDLE;
        else if (last_mode_s)              state_nxt_s = ST_FINISH;
        else                               state_nxt_s = ST_SETTLE;
      end
      ST_FINISH: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // sequencing registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      mode_r    <= {UPR_W{1'b0}};
      upr_r     <= {UPR_W{1'b0}};
      dwell_r   <= TMR_ONE;
      timer_r   <= {DWELL_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      mode_ok_r <= {NUM_MODES{1'b0}};
      cnt1_r    <= {CNT_W{1'b0}};
      cnt2_r    <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (abort_s) begin
        busy_r    <= 1'b0;
        aborted_r <= 1'b1;
        done_r    <= 1'b0;
        timer_r   <= {DWELL_W{1'b0}};
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start) begin
              dwell_r   <= eff_dwell(dwell);
              mode_ok_r <= {NUM_MODES{1'b0}};
              cnt1_r    <= {CNT_W{1'b0}};
              cnt2_r    <= {CNT_W{1'b0}};
              done_r    <= 1'b0;
              aborted_r <= 1'b0;
              mode_r    <= {UPR_W{1'b0}};
              upr_r     <= {UPR_W{1'b0}};
              busy_r    <= 1'b1;
              timer_r   <= {DWELL_W{1'b0}};
            end else begin
              upr_r <= manual_en ? manual_upr : {UPR_W{1'b0}};
            end
          end
          ST_SETTLE:  timer_r <= (timer_r == SETTLE_LAST)  ? {DWELL_W{1'b0}} : timer_r + TMR_ONE;
          ST_MEASURE: timer_r <= (timer_r == dwell_last_s) ? {DWELL_W{1'b0}} : timer_r + TMR_ONE;
          ST_EVAL: begin
            cnt1_r <= cnt1_s;
            cnt2_r <= cnt2_s;
            if (pass_s) mode_ok_r <= mode_ok_r | mode_bit_s;
            if (!last_mode_s) begin
              mode_r <= mode_inc_s;
              upr_r  <= mode_inc_s;
            end
          end
          ST_FINISH: begin
            done_r <= 1'b1;
            busy_r <= 1'b0;
          end
          default: busy_r <= 1'b0;
        endcase
      end
    end
  end

endmodule
